// File: rtl/mimo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mimo_pkg
//  Description : Types and constants shared by the QR/MIMO detector blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package mimo_pkg;

    // IEEE-754 single-precision word as carried on the datapath.
    typedef logic [31:0] float32_t;

    // Cycles from an operand being registered at the inv_sqrt input to its result.
    localparam int INV_SQRT_LAT = 3;

endpackage : mimo_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Picks the first valid
//                requester at or above the pointer, wrapping modulo N.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_valid,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan offsets from highest to lowest so the smallest offset from the pointer wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (i_valid[(int'(i_ptr) + j) % N]) begin
                o_grant                           = '0;
                o_grant[(int'(i_ptr) + j) % N]    = 1'b1;
                o_idx                             = IW'((int'(i_ptr) + j) % N);
                o_any                             = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/inv_sqrt_sched.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sqrt_sched
//  Description : Round-robin scheduler sharing one free-running inv_sqrt pipe
//                among N_REQ requesters. Operands are tagged with the
//                requester ID and results are returned on a shared bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_sqrt_sched
    import mimo_pkg::*;
#(
    parameter int  N_REQ    = 4,
    parameter int  I_DATA   = 32,
    parameter int  PIPE_LAT = INV_SQRT_LAT,
    localparam int ID_W     = $clog2(N_REQ),
    localparam int CNT_W    = $clog2(PIPE_LAT + 2)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*I_DATA-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    hold,
    output logic                    pipe_enable,
    output logic [I_DATA-1:0]       pipe_idata,
    input  logic [I_DATA-1:0]       pipe_odata,
    input  logic                    pipe_out_valid,
    output logic                    resp_valid,
    output logic [ID_W-1:0]         resp_id,
    output logic [I_DATA-1:0]       resp_data,
    output logic [CNT_W-1:0]        inflight,
    output logic                    idle,
    output logic                    err_sticky
);

    // Entry 0 mirrors the pipe_idata register; entries 1..PIPE_LAT follow the
    // operand through the pipe so the last entry lines up with pipe_odata.
    localparam int c_TAG_DEPTH = PIPE_LAT + 1;

    logic [N_REQ-1:0]       w_req_eff;
    logic [N_REQ-1:0]       w_grant;
    logic [ID_W-1:0]        w_grant_idx;
    logic                   w_grant_any;
    logic [ID_W-1:0]        r_ptr;
    logic [c_TAG_DEPTH-1:0] r_tag_vld;
    logic [ID_W-1:0]        r_tag_id [c_TAG_DEPTH];
    logic                   w_exit_vld;
    logic [ID_W-1:0]        w_exit_id;

    assign w_req_eff  = hold ? '0 : req_valid;
    assign req_ready  = w_grant;
    assign w_exit_vld = r_tag_vld[c_TAG_DEPTH-1];
    assign w_exit_id  = r_tag_id[c_TAG_DEPTH-1];
    assign idle       = (inflight == '0) && !w_grant_any;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .i_valid (w_req_eff),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    // Issue stage: advance the RR pointer, launch the operand and tag it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            pipe_enable <= 1'b0;
            pipe_idata  <= '0;
            r_tag_vld   <= '0;
            for (int k = 0; k < c_TAG_DEPTH; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            pipe_enable <= 1'b1;
            if (w_grant_any) begin
                r_ptr      <= (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
                pipe_idata <= req_data[int'(w_grant_idx)*I_DATA +: I_DATA];
            end
            r_tag_vld   <= {r_tag_vld[c_TAG_DEPTH-2:0], w_grant_any};
            r_tag_id[0] <= w_grant_idx;
            for (int k = 1; k < c_TAG_DEPTH; k++) begin
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    // Result path: capture the pipe output whenever a tagged operand exits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            err_sticky <= 1'b0;
        end else begin
            resp_valid <= w_exit_vld;
            if (w_exit_vld) begin
                resp_id   <= w_exit_id;
                resp_data <= pipe_odata;
            end
            if (w_exit_vld && !pipe_out_valid) begin
                err_sticky <= 1'b1;
            end
        end
    end

    // Occupancy: count up on each issue, down on each returned result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inflight <= '0;
        end else begin
            case ({w_grant_any, w_exit_vld})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule : inv_sqrt_sched
`default_nettype wire

// File: tb/tb_inv_sqrt_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_sqrt_sched
//  Description : Self-checking bench for inv_sqrt_sched with a stub pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_sqrt_sched;
    import mimo_pkg::*;

    localparam int N_REQ    = 4;
    localparam int I_DATA   = 32;
    localparam int PIPE_LAT = INV_SQRT_LAT;
    localparam int ID_W     = $clog2(N_REQ);
    localparam int CNT_W    = $clog2(PIPE_LAT + 2);

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*I_DATA-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    hold;
    logic                    pipe_enable;
    logic [I_DATA-1:0]       pipe_idata;
    logic [I_DATA-1:0]       pipe_odata;
    logic                    pipe_out_valid;
    logic                    resp_valid;
    logic [ID_W-1:0]         resp_id;
    logic [I_DATA-1:0]       resp_data;
    logic [CNT_W-1:0]        inflight;
    logic                    idle;
    logic                    err_sticky;
    logic                    force_ov;

    always #5 clk = ~clk;

    inv_sqrt_sched dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .hold           (hold),
        .pipe_enable    (pipe_enable),
        .pipe_idata     (pipe_idata),
        .pipe_odata     (pipe_odata),
        .pipe_out_valid (pipe_out_valid),
        .resp_valid     (resp_valid),
        .resp_id        (resp_id),
        .resp_data      (resp_data),
        .inflight       (inflight),
        .idle           (idle),
        .err_sticky     (err_sticky)
    );

    // Stand-in for the inv_sqrt core: fast-inverse-sqrt seed estimate.
    function automatic float32_t pipe_fn(input float32_t x);
        return 32'h5F3759DF - (x >> 1);
    endfunction

    // Stub pipe: result and out_valid appear PIPE_LAT edges after pipe_idata/pipe_enable.
    float32_t            stub_d [PIPE_LAT];
    logic [PIPE_LAT-1:0] stub_v = '0;
    always @(posedge clk) begin
        stub_d[0] <= pipe_fn(pipe_idata);
        for (int k = 1; k < PIPE_LAT; k++) stub_d[k] <= stub_d[k-1];
        stub_v <= {stub_v[PIPE_LAT-2:0], pipe_enable};
    end
    assign pipe_odata     = stub_d[PIPE_LAT-1];
    assign pipe_out_valid = stub_v[PIPE_LAT-1] & ~force_ov;

    typedef struct {
        int       id;
        float32_t data;
        int       accept;   // edge index at which the operand was accepted
        int       due;      // edge index at which resp_valid must be registered
    } exp_t;

    exp_t q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   rd_idx     = 0;
    int   last_reset = 0;
    int   ptr_m      = 0;
    logic err_exp    = 1'b0;
    logic en_exp     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic dropped(input exp_t e, input int rst_edge);
        return (e.accept < rst_edge) && (e.due >= rst_edge);
    endfunction

    // Monitor: whenever a response is (or should be) present, pop and compare.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic present;
        while (rd_idx < q.size() && dropped(q[rd_idx], last_reset)) rd_idx++;
        present = (rd_idx < q.size()) && (q[rd_idx].due <= cyc);
        checks++;
        if (resp_valid !== present) begin
            failures++;
            $display("FAIL resp_valid cyc=%0d actual=%b required=%b", cyc, resp_valid, present);
        end
        if (present) begin
            e = q[rd_idx];
            rd_idx++;
            if (resp_valid === 1'b1) begin
                checks += 2;
                if (int'(resp_id) != e.id) begin
                    failures++;
                    $display("FAIL resp_id cyc=%0d actual=%0d required=%0d", cyc, resp_id, e.id);
                end
                if (resp_data !== e.data) begin
                    failures++;
                    $display("FAIL resp_data cyc=%0d actual=%h required=%h", cyc, resp_data, e.data);
                end
            end
        end
    end

    // Predictor: round-robin reference, occupancy, flags; pushes expected results.
    always @(negedge clk) begin : predictor
        int               live;
        logic             exit_now;
        int               gi;
        logic [N_REQ-1:0] exp_ready;
        #1;
        live     = 0;
        exit_now = 1'b0;
        foreach (q[i]) begin
            if (!dropped(q[i], last_reset) && q[i].due > cyc) begin
                live++;
                if (q[i].due == cyc + 1) exit_now = 1'b1;
            end
        end
        checks += 3;
        if (inflight !== CNT_W'(live)) begin
            failures++;
            $display("FAIL inflight cyc=%0d actual=%0d required=%0d", cyc, inflight, live);
        end
        if (pipe_enable !== en_exp) begin
            failures++;
            $display("FAIL pipe_enable cyc=%0d actual=%b required=%b", cyc, pipe_enable, en_exp);
        end
        if (err_sticky !== err_exp) begin
            failures++;
            $display("FAIL err_sticky cyc=%0d actual=%b required=%b", cyc, err_sticky, err_exp);
        end
        if (!reset_n) begin
            last_reset = cyc + 1;
            ptr_m      = 0;
            err_exp    = 1'b0;
            en_exp     = 1'b0;
        end else begin
            gi = -1;
            if (!hold) begin
                for (int j = 0; j < N_REQ; j++) begin
                    if (gi < 0 && req_valid[(ptr_m + j) % N_REQ]) gi = (ptr_m + j) % N_REQ;
                end
            end
            exp_ready = '0;
            if (gi >= 0) exp_ready[gi] = 1'b1;
            checks += 2;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL req_ready cyc=%0d actual=%b required=%b", cyc, req_ready, exp_ready);
            end
            if (idle !== ((live == 0) && (gi < 0))) begin
                failures++;
                $display("FAIL idle cyc=%0d actual=%b required=%b", cyc, idle, (live == 0) && (gi < 0));
            end
            if (force_ov && exit_now) err_exp = 1'b1;
            if (gi >= 0) begin
                q.push_back('{id: gi, data: pipe_fn(req_data[gi*I_DATA +: I_DATA]),
                              accept: cyc + 1, due: cyc + 2 + PIPE_LAT});
                ptr_m = (gi + 1) % N_REQ;
            end
            en_exp = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N_REQ; i++) req_data[i*I_DATA +: I_DATA] = $urandom;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        hold      = 1'b0;
        force_ov  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single operand from requester 2.
        req_data[2*I_DATA +: I_DATA] = 32'h4000_0000;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (8) tick();

        // All requesters valid for 8 cycles.
        for (int c = 0; c < 8; c++) begin
            rand_data();
            req_valid = 4'b1111;
            tick();
        end
        req_valid = '0;
        repeat (8) tick();

        // Sole requester 1 for 5 cycles.
        req_data[1*I_DATA +: I_DATA] = 32'h3E20_0000;
        req_valid = 4'b0010;
        repeat (5) tick();
        req_valid = '0;
        repeat (8) tick();

        // Two grants, then hold while requests stay valid.
        rand_data();
        req_valid = 4'b1111;
        repeat (2) tick();
        hold = 1'b1;
        repeat (8) tick();
        hold      = 1'b0;
        req_valid = '0;
        repeat (4) tick();

        // Randomised traffic.
        for (int c = 0; c < 300; c++) begin
            rand_data();
            req_valid = 4'($urandom_range(0, 15));
            hold      = ($urandom_range(0, 7) == 0);
            tick();
        end
        req_valid = '0;
        hold      = 1'b0;
        repeat (8) tick();

        // Reset with three operations in flight.
        rand_data();
        req_valid = 4'b1111;
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        req_valid = 4'b1010;
        tick();
        req_valid = '0;
        repeat (8) tick();

        // Force out_valid low on the exit cycle of one operand.
        rand_data();
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (PIPE_LAT) tick();
        force_ov = 1'b1;
        tick();
        force_ov = 1'b0;
        repeat (6) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_inv_sqrt_sched
`default_nettype wire
